// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-FF synchroniser, 3-sample majority vote per bit,
// configurable width/parity/stop bits, valid/ready output with overrun and break reporting.
module uart_rx_os #(
   parameter int WIDTH      = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY     = 2,
   parameter int STOP_BITS  = 1
) (
   input  logic             rx_clk,
   input  logic             rx_reset,
   input  logic             rx,
   input  logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] data_out,
   output logic             parity_err,
   output logic             frame_err,
   output logic             break_det,
   output logic             overrun
);

   localparam int MID = OVERSAMPLE / 2;
   localparam int TW  = $clog2(OVERSAMPLE);
   localparam int BW  = $clog2(WIDTH);

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_HIGH} state_t;

   logic [1:0]       sync_reg;
   logic             rx_s;
   state_t           state_reg, state_next;
   logic [TW-1:0]    tick_reg, tick_next;
   logic [BW-1:0]    bit_cnt_reg, bit_cnt_next;
   logic [WIDTH-1:0] shift_reg, shift_next;
   logic             par_bit_reg, par_bit_next;
   logic             perr_reg, perr_next;
   logic             ferr_reg, ferr_next;
   logic             samp0_reg, samp1_reg;
   logic             tick_last, decide, bit_val;
   logic             complete, frame_ferr, frame_brk;

   assign rx_s      = sync_reg[1];
   assign tick_last = (tick_reg == TW'(OVERSAMPLE - 1));
   assign decide    = (tick_reg == TW'(MID + 1));
   // Majority of the samples taken at MID-1, MID and the current MID+1 tick.
   assign bit_val   = (samp0_reg & samp1_reg) | (samp0_reg & rx_s) | (samp1_reg & rx_s);

   assign frame_ferr = ferr_reg | ~bit_val;
   assign frame_brk  = (shift_reg == '0) && !bit_val && ((PARITY == 0) || !par_bit_reg);

   always_comb begin
      state_next   = state_reg;
      tick_next    = tick_last ? '0 : tick_reg + TW'(1);
      bit_cnt_next = bit_cnt_reg;
      shift_next   = shift_reg;
      par_bit_next = par_bit_reg;
      perr_next    = perr_reg;
      ferr_next    = ferr_reg;
      complete     = 1'b0;
      case (state_reg)
         IDLE: begin
            tick_next    = '0;
            bit_cnt_next = '0;
            if (!rx_s) begin
               state_next   = START;
               par_bit_next = 1'b0;
               perr_next    = 1'b0;
               ferr_next    = 1'b0;
            end
         end
         START: begin
            if (decide && bit_val) begin
               state_next = IDLE;
               tick_next  = '0;
            end else if (tick_last) begin
               state_next   = DATA;
               bit_cnt_next = '0;
            end
         end
         DATA: begin
            if (decide) shift_next = {bit_val, shift_reg[WIDTH-1:1]};
            if (tick_last) begin
               if (bit_cnt_reg == BW'(WIDTH - 1)) begin
                  bit_cnt_next = '0;
                  state_next   = (PARITY != 0) ? PAR : STOP;
               end else begin
                  bit_cnt_next = bit_cnt_reg + BW'(1);
               end
            end
         end
         PAR: begin
            if (decide) begin
               par_bit_next = bit_val;
               perr_next    = ((^shift_reg) ^ bit_val) != (PARITY == 2);
            end
            if (tick_last) begin
               state_next   = STOP;
               bit_cnt_next = '0;
            end
         end
         STOP: begin
            if (decide) begin
               if (!bit_val) ferr_next = 1'b1;
               // Leave at the last stop bit's decision so an early start edge is seen.
               if (bit_cnt_reg == BW'(STOP_BITS - 1)) begin
                  complete   = 1'b1;
                  tick_next  = '0;
                  state_next = bit_val ? IDLE : WAIT_HIGH;
               end
            end
            if (tick_last) bit_cnt_next = bit_cnt_reg + BW'(1);
         end
         WAIT_HIGH: begin
            tick_next = '0;
            if (rx_s) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge rx_clk or negedge rx_reset) begin
      if (!rx_reset) begin
         sync_reg    <= 2'b11;
         state_reg   <= IDLE;
         tick_reg    <= '0;
         bit_cnt_reg <= '0;
         shift_reg   <= '0;
         par_bit_reg <= 1'b0;
         perr_reg    <= 1'b0;
         ferr_reg    <= 1'b0;
         samp0_reg   <= 1'b1;
         samp1_reg   <= 1'b1;
      end else begin
         sync_reg    <= {sync_reg[0], rx};
         state_reg   <= state_next;
         tick_reg    <= tick_next;
         bit_cnt_reg <= bit_cnt_next;
         shift_reg   <= shift_next;
         par_bit_reg <= par_bit_next;
         perr_reg    <= perr_next;
         ferr_reg    <= ferr_next;
         if (tick_reg == TW'(MID - 1)) samp0_reg <= rx_s;
         if (tick_reg == TW'(MID))     samp1_reg <= rx_s;
      end
   end

   always_ff @(posedge rx_clk or negedge rx_reset) begin
      if (!rx_reset) begin
         valid      <= 1'b0;
         data_out   <= '0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         break_det  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         break_det <= complete && frame_brk;
         overrun   <= complete && valid && !ready;
         if (complete && (!valid || ready)) begin
            valid      <= 1'b1;
            data_out   <= shift_reg;
            parity_err <= (PARITY != 0) && perr_reg;
            frame_err  <= frame_ferr;
         end else if (valid && ready) begin
            valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: default config (dut0) and a 7N2 x8 config (dut1).
module tb_uart_rx_os;

   typedef struct packed {
      logic [8:0] d;
      logic       pe;
      logic       fe;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx0, rdy0, v0, pe0, fe0, bk0, ov0;
   logic [7:0] d0;
   logic       rx1, rdy1, v1, pe1, fe1, bk1, ov1;
   logic [6:0] d1;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   int         brk0 = 0;
   int         ovr0 = 0;
   logic       chk_low0 = 1'b0;
   logic       chk_low1 = 1'b0;
   exp_t       q0[$];
   exp_t       q1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_rx_os dut0 (
      .rx_clk(clk), .rx_reset(rst_n), .rx(rx0), .ready(rdy0), .valid(v0),
      .data_out(d0), .parity_err(pe0), .frame_err(fe0), .break_det(bk0), .overrun(ov0)
   );

   uart_rx_os #(.WIDTH(7), .OVERSAMPLE(8), .PARITY(0), .STOP_BITS(2)) dut1 (
      .rx_clk(clk), .rx_reset(rst_n), .rx(rx1), .ready(rdy1), .valid(v1),
      .data_out(d1), .parity_err(pe1), .frame_err(fe1), .break_det(bk1), .overrun(ov1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] f0(input logic [7:0] d, input logic p, input logic s);
      return {21'b0, s, p, d, 1'b0};
   endfunction

   function automatic logic [31:0] f1(input logic [6:0] d, input logic s1, input logic s2);
      return {22'b0, s2, s1, d, 1'b0};
   endfunction

   // Drives n bits (LSB first), one bit time each; entered and left at posedge+1.
   task automatic send_bits(input int which, input logic [31:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         if (which == 0) rx0 = bits[i];
         else            rx1 = bits[i];
         repeat ((which == 0) ? 16 : 8) @(posedge clk);
         #1;
      end
   endtask

   task automatic idle(input int which, input int nbits);
      if (which == 0) rx0 = 1'b1;
      else            rx1 = 1'b1;
      repeat (nbits * ((which == 0) ? 16 : 8)) @(posedge clk);
      #1;
   endtask

   task automatic wait_lat(input int which, input int c0, input int nominal);
      int  n;
      int  lat;
      logic got;
      n   = 0;
      got = 1'b0;
      while (n < 400 && !got) begin
         @(negedge clk);
         n++;
         got = (which == 0) ? v0 : v1;
      end
      if (!got) begin
         check("latency_timeout", 32'(got), 32'd1);
      end else begin
         lat = cyc - c0 - 1;
         checks++;
         if (lat < nominal - 1 || lat > nominal + 1) begin
            errors++;
            $display("FAIL latency%0d actual=%0d required=%0d+/-1", which, lat, nominal);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int   c0;
      rst_n = 1'b0;
      rx0 = 1'b1; rx1 = 1'b1; rdy0 = 1'b1; rdy1 = 1'b1;

      fork
         forever begin
            @(negedge clk);
            if (chk_low0) begin check("valid0_clear", 32'(v0), 32'd0); chk_low0 = 1'b0; end
            if (chk_low1) begin check("valid1_clear", 32'(v1), 32'd0); chk_low1 = 1'b0; end
            if (bk0) brk0++;
            if (ov0) ovr0++;
            if (rst_n && v0 && rdy0) begin
               if (q0.size() == 0) check("unexpected_frame0", 32'(v0), 32'd0);
               else begin
                  e = q0.pop_front();
                  $display("dut0 frame data=%02h perr=%0d ferr=%0d", d0, pe0, fe0);
                  check("data0", 32'(d0), 32'(e.d));
                  check("perr0", 32'(pe0), 32'(e.pe));
                  check("ferr0", 32'(fe0), 32'(e.fe));
                  chk_low0 = 1'b1;
               end
            end
            if (rst_n && v1 && rdy1) begin
               if (q1.size() == 0) check("unexpected_frame1", 32'(v1), 32'd0);
               else begin
                  e = q1.pop_front();
                  $display("dut1 frame data=%02h perr=%0d ferr=%0d", d1, pe1, fe1);
                  check("data1", 32'(d1), 32'(e.d));
                  check("perr1", 32'(pe1), 32'(e.pe));
                  check("ferr1", 32'(fe1), 32'(e.fe));
                  chk_low1 = 1'b1;
               end
            end
         end
      join_none

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid0", 32'(v0), 32'd0);
      check("rst_data0", 32'(d0), 32'd0);
      check("rst_flags0", 32'({pe0, fe0, bk0, ov0}), 32'd0);
      check("rst_valid1", 32'(v1), 32'd0);
      check("rst_flags1", 32'({pe1, fe1, bk1, ov1}), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (4) @(posedge clk); #1;

      // 0xA5 with correct odd parity, latency measured from the start edge
      q0.push_back('{d: 9'h0A5, pe: 1'b0, fe: 1'b0});
      c0 = cyc;
      fork
         send_bits(0, f0(8'hA5, 1'b1, 1'b1), 11);
         wait_lat(0, c0, 172);
      join
      idle(0, 2);

      // 0x3C with the wrong parity bit
      q0.push_back('{d: 9'h03C, pe: 1'b1, fe: 1'b0});
      send_bits(0, f0(8'h3C, 1'b0, 1'b1), 11);
      idle(0, 2);

      // 4-cycle glitch is rejected, following frame is clean
      rx0 = 1'b0;
      repeat (4) @(posedge clk); #1;
      idle(0, 3);
      q0.push_back('{d: 9'h05A, pe: 1'b0, fe: 1'b0});
      send_bits(0, f0(8'h5A, 1'b1, 1'b1), 11);
      idle(0, 2);

      // 0x55 with a low stop bit, line held low, then 0x81
      q0.push_back('{d: 9'h055, pe: 1'b0, fe: 1'b1});
      send_bits(0, f0(8'h55, 1'b1, 1'b0), 11);
      repeat (32) @(posedge clk); #1;
      idle(0, 2);
      q0.push_back('{d: 9'h081, pe: 1'b0, fe: 1'b0});
      send_bits(0, f0(8'h81, 1'b1, 1'b1), 11);
      idle(0, 2);

      // Break: 12 bit times low
      q0.push_back('{d: 9'h000, pe: 1'b1, fe: 1'b1});
      rx0 = 1'b0;
      repeat (12 * 16) @(posedge clk); #1;
      idle(0, 2);
      check("break_count", brk0, 32'd1);

      // Overrun: 0x11 held, 0x22 dropped
      @(posedge clk); #1;
      rdy0 = 1'b0;
      q0.push_back('{d: 9'h011, pe: 1'b0, fe: 1'b0});
      send_bits(0, f0(8'h11, 1'b1, 1'b1), 11);
      send_bits(0, f0(8'h22, 1'b1, 1'b1), 11);
      idle(0, 2);
      @(negedge clk);
      check("overrun_count", ovr0, 32'd1);
      check("held_valid", 32'(v0), 32'd1);
      check("held_data", 32'(d0), 32'h11);
      @(posedge clk); #1;
      rdy0 = 1'b1;
      idle(0, 1);

      // Reset in the middle of the data bits
      send_bits(0, f0(8'h0F, 1'b1, 1'b1), 4);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("midrst_valid", 32'(v0), 32'd0);
      check("midrst_data", 32'(d0), 32'd0);
      check("midrst_flags", 32'({pe0, fe0, bk0, ov0}), 32'd0);
      rx0 = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(0, 2);
      q0.push_back('{d: 9'h0F0, pe: 1'b0, fe: 1'b0});
      send_bits(0, f0(8'hF0, 1'b1, 1'b1), 11);
      idle(0, 2);

      // 7-bit, no parity, 2 stop bits, x8 oversampling
      q1.push_back('{d: 9'h025, pe: 1'b0, fe: 1'b0});
      c0 = cyc;
      fork
         send_bits(1, f1(7'h25, 1'b1, 1'b1), 10);
         wait_lat(1, c0, 80);
      join
      idle(1, 2);
      q1.push_back('{d: 9'h07F, pe: 1'b0, fe: 1'b1});
      send_bits(1, f1(7'h7F, 1'b1, 1'b0), 10);
      repeat (16) @(posedge clk); #1;
      idle(1, 3);

      check("q0_drained", q0.size(), 32'd0);
      check("q1_drained", q1.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
